inst_fetch: RTL and testbench
=============================

Name: inst_fetch

Overview:
- Fetch stage directly downstream of the PC register.
- Takes the current PC and chip-enable, runs one-outstanding-request transactions on the instruction-memory port, and buffers the returned {pc, inst} pairs in a small FIFO for the IF/ID register.
- Back-pressures the PC register through ctrl via stallreq_o.
- Discards in-flight and buffered fetches when decode signals a taken branch.

Parameters:
- DEPTH, 2, number of {pc, inst} entries in the fetch buffer; power of two, at least 2.
- AW, 32, instruction address width; matches InstAddrBus.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; synchronous, active-high, equal to RstEnable.
- pc_i  in  AW  current PC from the PC register.
- ce_i  in  1  chip enable from the PC register; ChipDisable means no fetch activity.
- stall  in  6  ctrl stall vector; stall[1]=1 means decode is not consuming this cycle.
- flush_i  in  1  taken-branch flag from id, the same signal that redirects the PC register.
- imem_req_o  out  1  memory request.
- imem_addr_o  out  AW  request address; equals pc_i, unmodified.
- imem_gnt_i  in  1  request accepted in this cycle.
- imem_rvalid_i  in  1  read data valid.
- imem_rdata_i  in  32  instruction word.
- if_pc_o  out  AW  PC of the buffer head.
- if_inst_o  out  32  instruction at the buffer head.
- if_valid_o  out  1  buffer head is valid.
- stallreq_o  out  1  to ctrl; holds the PC register when high.

Behaviour:
- Reset, synchronous on rst=1 at a clk edge:
  - State goes to IDLE; FIFO count, read pointer and write pointer go to 0.
  - All outputs are 0: imem_req_o, imem_addr_o, if_pc_o, if_inst_o, if_valid_o, stallreq_o.
  - Reset asserted mid-transaction abandons it. A later imem_rvalid_i is ignored in IDLE.
- FSM states:
  - IDLE
    - Go to REQ when ce_i=ChipEnable and (count + 1) <= DEPTH (room reserved for the outstanding entry) and flush_i=0.
  - REQ
    - imem_req_o=1 and imem_addr_o=pc_i.
    - On imem_gnt_i=1 go to RESP, and latch pc_i as the in-flight PC.
    - Without a grant, stay in REQ; pc_i is guaranteed stable because stallreq_o=1.
  - RESP
    - Wait for imem_rvalid_i=1, then push {in-flight PC, imem_rdata_i}.
    - Next state is REQ if the issue conditions still hold; otherwise IDLE.
    - Minimum issue-to-push latency is 2 cycles: grant, then rvalid.
  - DROP
    - Wait for imem_rvalid_i=1 and discard the data, then go to IDLE.
- stallreq_o rule:
  - stallreq_o = ce_i & ~flush_i & ~(imem_req_o & imem_gnt_i).
  - The PC advances only in the grant cycle. At most one outstanding request exists at any time.
- Output side:
  - if_valid_o = (count != 0); if_pc_o and if_inst_o show the FIFO head.
  - Pop when if_valid_o=1 and stall[1]=0.
  - Push and pop in the same cycle are both performed; this is legal even when the FIFO is full.
  - Pointers wrap modulo DEPTH.
- Flush (flush_i=1) takes priority over every other event in that cycle:
  - FIFO is emptied; count is 0 in the next cycle.
  - imem_req_o is forced to 0 and stallreq_o is 0, so the PC register loads the branch target.
  - In REQ: go to IDLE; the un-granted request is withdrawn.
  - In RESP with no rvalid this cycle: go to DROP.
  - In RESP with rvalid this cycle: data dropped, go to IDLE.
  - The first fetch of the target is issued in the next cycle at the earliest.
- ce_i=ChipDisable:
  - No new request and stallreq_o=0.
  - An outstanding response still completes and is pushed.
  - The buffer keeps draining.

Decomposition:
- Shared defines (defines.v): RstEnable, ChipEnable/ChipDisable, InstAddrBus, InstBus, and the FSM state encodings IF_IDLE/IF_REQ/IF_RESP/IF_DROP as 2-bit constants.
- One natural sub-module, fetch_fifo: synchronous FIFO, parameters DEPTH and WIDTH=AW+32, with push/pop/flush/count. Its count is used for the room check.

Test Plan:
- Reset, then ce_i=1, pc_i=0x0, zero-wait memory (gnt in the request cycle, rvalid next cycle) -> if_valid_o=1 with if_pc_o=0x0 and if_inst_o=rdata after 2 cycles. stallreq_o is low in grant cycles, and PCs 0x0, 0x4, 0x8 appear in order.
- Grant delayed 3 cycles at pc_i=0x10 -> imem_req_o high with addr 0x10 throughout, and stallreq_o=1 for 3 cycles. Exactly one FIFO entry, with pc 0x10.
- stall[1]=1 held with DEPTH=2 -> after 2 pushes there is no request and stallreq_o=1. Releasing stall[1] pops 0x20, and a request for the next PC issues the following cycle.
- flush_i=1 while in RESP for pc 0x30 with 1 buffered entry -> if_valid_o=0 next cycle. State goes to DROP, and the late rdata 0xDEADBEEF is never output. The next request has the addr of the new pc_i (0x100).
- flush_i and imem_rvalid_i in the same cycle -> data dropped, FIFO empty, state IDLE, stallreq_o=0 that cycle.
- rst=1 asserted while in RESP, then rvalid arrives one cycle after reset deasserts -> all outputs 0 and the rvalid is ignored. Normal fetch resumes at the pc_i value present after reset.

Source files
------------

// File: rtl/inst_fetch_pkg.sv
// -----------------------------------------------------------------------------
// inst_fetch_pkg
// Shared constants for the fetch stage: reset and chip-enable levels, bus
// widths, the fetch FSM state encoding and the buffer room check.
// -----------------------------------------------------------------------------
package inst_fetch_pkg;

   localparam logic RST_ENABLE    = 1'b1;
   localparam logic CHIP_ENABLE   = 1'b1;
   localparam logic CHIP_DISABLE  = 1'b0;
   localparam int   INST_ADDR_BUS = 32;
   localparam int   INST_BUS      = 32;

   typedef enum logic [1:0] {
      IF_IDLE = 2'b00,
      IF_REQ  = 2'b01,
      IF_RESP = 2'b10,
      IF_DROP = 2'b11
   } if_state_e;

   // True when one more entry still fits, i.e. the next fetch has a slot
   // reserved for it before it is issued.
   function automatic logic has_room(input int cnt, input int depth);
      return ((cnt + 32'sd1) <= depth);
   endfunction

endpackage

// File: rtl/fetch_fifo.sv
// -----------------------------------------------------------------------------
// fetch_fifo
// Synchronous FIFO holding {pc, inst} pairs between the fetch FSM and IF/ID.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   i_push        write i_wdata at the tail
//   i_pop         drop the head entry (caller guarantees non-empty)
//   i_flush       empty the FIFO; wins over push and pop
//   i_wdata       entry to write
//   o_rdata       head entry (combinational read)
//   o_count       current occupancy, 0..DEPTH
// -----------------------------------------------------------------------------
module fetch_fifo #(
   parameter int  DEPTH = 2,
   parameter int  WIDTH = 64,
   localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int CW    = PW + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_push,
   input  logic             i_pop,
   input  logic             i_flush,
   input  logic [WIDTH-1:0] i_wdata,
   output logic [WIDTH-1:0] o_rdata,
   output logic [CW-1:0]    o_count
);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PW-1:0]    r_rptr;
   logic [PW-1:0]    r_wptr;
   logic [CW-1:0]    r_count;

   // pointers and occupancy; DEPTH is a power of two so pointers wrap naturally
   always_ff @(posedge clk) begin
      if (rst) begin
         r_rptr  <= {PW{1'b0}};
         r_wptr  <= {PW{1'b0}};
         r_count <= {CW{1'b0}};
      end else if (i_flush) begin
         r_rptr  <= {PW{1'b0}};
         r_wptr  <= {PW{1'b0}};
         r_count <= {CW{1'b0}};
      end else begin
         if (i_push) begin
            r_wptr <= r_wptr + PW'(1'b1);
         end
         if (i_pop) begin
            r_rptr <= r_rptr + PW'(1'b1);
         end
         r_count <= r_count + CW'(i_push) - CW'(i_pop);
      end
   end

   // entry storage; contents need no reset because the count gates reads
   always_ff @(posedge clk) begin
      if (i_push && !i_flush && !rst) begin
         r_mem[r_wptr] <= i_wdata;
      end
   end

   assign o_rdata = r_mem[r_rptr];
   assign o_count = r_count;

endmodule

// File: rtl/inst_fetch.sv
// -----------------------------------------------------------------------------
// inst_fetch
// Fetch stage behind the PC register. Issues one instruction-memory request at
// a time, buffers returned {pc, inst} pairs for IF/ID, holds the PC register
// through stallreq_o, and discards in-flight/buffered fetches on a branch.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   pc_i, ce_i                current PC and chip enable from the PC register
//   stall[5:0]                ctrl stall vector; stall[1] = decode not consuming
//   flush_i                   taken branch from decode
//   imem_req_o/imem_addr_o    memory request and address (pc_i)
//   imem_gnt_i                request accepted this cycle
//   imem_rvalid_i/imem_rdata_i  returned instruction
//   if_pc_o/if_inst_o/if_valid_o  buffer head towards IF/ID
//   stallreq_o                hold request towards ctrl
// -----------------------------------------------------------------------------
module inst_fetch
   import inst_fetch_pkg::*;
#(
   parameter int DEPTH = 2,
   parameter int AW    = INST_ADDR_BUS
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [AW-1:0]       pc_i,
   input  logic                ce_i,
   input  logic [5:0]          stall,
   input  logic                flush_i,
   output logic                imem_req_o,
   output logic [AW-1:0]       imem_addr_o,
   input  logic                imem_gnt_i,
   input  logic                imem_rvalid_i,
   input  logic [INST_BUS-1:0] imem_rdata_i,
   output logic [AW-1:0]       if_pc_o,
   output logic [INST_BUS-1:0] if_inst_o,
   output logic                if_valid_o,
   output logic                stallreq_o
);

   localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW    = PW + 1;
   localparam int WIDTH = AW + INST_BUS;

   if_state_e        r_state;
   if_state_e        w_state_next;
   logic [AW-1:0]    r_pc_inflight;
   logic [CW-1:0]    w_count;
   logic [CW-1:0]    w_count_after;
   logic [WIDTH-1:0] w_head;
   logic             w_valid;
   logic             w_push;
   logic             w_pop;
   logic             w_req;
   logic [AW-1:0]    w_addr;
   logic             w_stallreq;
   logic             w_unused_stall;

   // only the decode stall bit matters to this stage
   assign w_unused_stall = ^{stall[5:2], stall[0]};

   assign w_valid = (w_count != {CW{1'b0}});
   assign w_push  = (r_state == IF_RESP) && imem_rvalid_i && !flush_i;
   assign w_pop   = w_valid && !stall[1] && !flush_i;

   // Occupancy once this cycle's push/pop land; used when deciding to re-issue
   // straight out of RESP so the next entry already has its slot.
   assign w_count_after = w_count + CW'(w_push) - CW'(w_pop);

   fetch_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (WIDTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (w_push),
      .i_pop   (w_pop),
      .i_flush (flush_i),
      .i_wdata ({r_pc_inflight, imem_rdata_i}),
      .o_rdata (w_head),
      .o_count (w_count)
   );

   // state register and capture of the PC whose request was just granted
   always_ff @(posedge clk) begin
      if (rst == RST_ENABLE) begin
         r_state       <= IF_IDLE;
         r_pc_inflight <= {AW{1'b0}};
      end else begin
         r_state <= w_state_next;
         if (w_req && imem_gnt_i) begin
            r_pc_inflight <= pc_i;
         end
      end
   end

   // next-state logic; a flush overrides every other event in the cycle
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         IF_IDLE: begin
            if (!flush_i && (ce_i == CHIP_ENABLE) && has_room(int'(w_count), DEPTH)) begin
               w_state_next = IF_REQ;
            end else begin
               w_state_next = IF_IDLE;
            end
         end
         IF_REQ: begin
            if (flush_i) begin
               w_state_next = IF_IDLE;
            end else if (imem_gnt_i) begin
               w_state_next = IF_RESP;
            end else begin
               w_state_next = IF_REQ;
            end
         end
         IF_RESP: begin
            if (flush_i) begin
               // response still owed by memory must be swallowed in DROP
               w_state_next = imem_rvalid_i ? IF_IDLE : IF_DROP;
            end else if (imem_rvalid_i) begin
               if ((ce_i == CHIP_ENABLE) && has_room(int'(w_count_after), DEPTH)) begin
                  w_state_next = IF_REQ;
               end else begin
                  w_state_next = IF_IDLE;
               end
            end else begin
               w_state_next = IF_RESP;
            end
         end
         IF_DROP: begin
            if (imem_rvalid_i) begin
               w_state_next = IF_IDLE;
            end else begin
               w_state_next = IF_DROP;
            end
         end
         default: begin
            w_state_next = IF_IDLE;
         end
      endcase
   end

   // memory request and PC hold; the PC may only move in a grant cycle
   always_comb begin
      w_req      = 1'b0;
      w_addr     = {AW{1'b0}};
      w_stallreq = 1'b0;
      if ((rst == RST_ENABLE) || flush_i) begin
         w_req      = 1'b0;
         w_addr     = {AW{1'b0}};
         w_stallreq = 1'b0;
      end else begin
         w_req  = (r_state == IF_REQ);
         w_addr = w_req ? pc_i : {AW{1'b0}};
         if (ce_i == CHIP_DISABLE) begin
            w_stallreq = 1'b0;
         end else begin
            w_stallreq = ~(w_req & imem_gnt_i);
         end
      end
   end

   // buffer head towards IF/ID, zero while nothing is buffered
   always_comb begin
      if_pc_o   = {AW{1'b0}};
      if_inst_o = {INST_BUS{1'b0}};
      if (w_valid) begin
         if_pc_o   = w_head[WIDTH-1:INST_BUS];
         if_inst_o = w_head[INST_BUS-1:0];
      end else begin
         if_pc_o   = {AW{1'b0}};
         if_inst_o = {INST_BUS{1'b0}};
      end
   end

   assign imem_req_o  = w_req;
   assign imem_addr_o = w_addr;
   assign stallreq_o  = w_stallreq;
   assign if_valid_o  = w_valid;

endmodule

// File: tb/tb_inst_fetch.sv
module tb_inst_fetch;

   localparam int DEPTH = 2;
   localparam int AW    = 32;

   logic          clk = 1'b0;
   logic          rst;
   logic [AW-1:0] pc_i;
   logic          ce_i;
   logic [5:0]    stall_w;
   logic          flush_w;
   logic          imem_req_o;
   logic [AW-1:0] imem_addr_o;
   logic          imem_gnt_i;
   logic          imem_rvalid_i;
   logic [31:0]   imem_rdata_i;
   logic [AW-1:0] if_pc_o;
   logic [31:0]   if_inst_o;
   logic          if_valid_o;
   logic          stallreq_o;

   always #5 clk = ~clk;

   inst_fetch #(.DEPTH(DEPTH), .AW(AW)) dut (
      .clk           (clk),
      .rst           (rst),
      .pc_i          (pc_i),
      .ce_i          (ce_i),
      .stall         (stall_w),
      .flush_i       (flush_w),
      .imem_req_o    (imem_req_o),
      .imem_addr_o   (imem_addr_o),
      .imem_gnt_i    (imem_gnt_i),
      .imem_rvalid_i (imem_rvalid_i),
      .imem_rdata_i  (imem_rdata_i),
      .if_pc_o       (if_pc_o),
      .if_inst_o     (if_inst_o),
      .if_valid_o    (if_valid_o),
      .stallreq_o    (stallreq_o)
   );

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
   } entry_t;

   // reference model: expected buffer contents and the PC register
   entry_t      q[$];
   logic [31:0] model_pc;

   // stimulus knobs
   logic        rst_d, ce, flush;
   logic [5:0]  stall;
   logic [31:0] flush_tgt;
   logic        rand_mode;
   int          gnt_wait, rv_wait;
   logic        force_en;
   logic [31:0] force_val;

   // memory model
   logic        mem_busy, mem_dead;
   logic [31:0] mem_pc, mem_data;
   int          rv_cnt, req_wait;

   // per-cycle snapshot of DUT outputs
   logic        s_req, s_gnt, s_rvalid, s_stallreq, s_valid;
   logic [31:0] s_addr, s_pc, s_inst;

   int n_checks = 0;
   int n_fail   = 0;
   int n_push   = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // one clock cycle: drive, sample, check against the model, advance the model
   task automatic cycle();
      logic do_pop;
      rst           = rst_d;
      pc_i          = model_pc;
      ce_i          = ce;
      stall_w       = stall;
      flush_w       = flush;
      imem_rvalid_i = mem_busy && (rv_cnt == 0);
      imem_rdata_i  = imem_rvalid_i ? mem_data : 32'h0;
      if (mem_busy)       imem_gnt_i = 1'b0;
      else if (rand_mode) imem_gnt_i = ($urandom_range(0, 2) != 0);
      else                imem_gnt_i = (req_wait >= gnt_wait);
      #1;
      s_req = imem_req_o;  s_gnt = imem_gnt_i;  s_rvalid = imem_rvalid_i;
      s_addr = imem_addr_o; s_stallreq = stallreq_o;
      s_valid = if_valid_o; s_pc = if_pc_o; s_inst = if_inst_o;

      chk("if_valid", 64'(s_valid), 64'(q.size() != 0));
      if (q.size() != 0) begin
         chk("if_pc", 64'(s_pc), 64'(q[0].pc));
         chk("if_inst", 64'(s_inst), 64'(q[0].inst));
      end
      chk("stallreq", 64'(s_stallreq), 64'(!rst_d && ce && !flush && !(s_req && s_gnt)));
      if (s_req) chk("req_addr", 64'(s_addr), 64'(model_pc));
      if (flush || rst_d) chk("req_blocked", 64'(s_req), 64'd0);
      if (mem_busy && !mem_dead) chk("one_outstanding", 64'(s_req), 64'd0);

      if (rst_d) begin
         q.delete();
         if (mem_busy) mem_dead = 1'b1;
      end else if (flush) begin
         q.delete();
         if (mem_busy && !s_rvalid) mem_dead = 1'b1;
      end else begin
         do_pop = (q.size() != 0) && !stall[1];
         if (do_pop) void'(q.pop_front());
         if (s_rvalid && !mem_dead) begin
            q.push_back('{pc: mem_pc, inst: mem_data});
            n_push++;
            chk("fifo_bound", 64'(q.size() <= DEPTH), 64'd1);
         end
      end

      if (s_rvalid) begin
         mem_busy = 1'b0;
         mem_dead = 1'b0;
      end else if (mem_busy) begin
         rv_cnt--;
      end
      if (s_req && s_gnt) begin
         mem_busy = 1'b1;
         mem_dead = 1'b0;
         mem_pc   = model_pc;
         mem_data = force_en ? force_val : $urandom;
         rv_cnt   = rand_mode ? $urandom_range(0, 3) : rv_wait;
         model_pc = model_pc + 32'd4;
      end
      if (s_req && !s_gnt) req_wait++;
      else                 req_wait = 0;
      if (flush && !rst_d) model_pc = flush_tgt;

      @(posedge clk);
      #1;
   endtask

   // return to an idle, empty DUT with directed-mode defaults
   task automatic drain();
      logic done;
      done = 1'b0;
      ce = 1'b0; stall = 6'b0; flush = 1'b0; rst_d = 1'b0; force_en = 1'b0;
      gnt_wait = 0; rv_wait = 0;
      for (int i = 0; i < 30 && !done; i++) begin
         cycle();
         if (!mem_busy && (q.size() == 0) && !s_req) done = 1'b1;
      end
      chk("drain_timeout", 64'(done), 64'd1);
   endtask

   initial begin : main
      int          first_valid, npop, held, cnt;
      logic        granted, found, seen, flag;
      logic [31:0] got_pc [3];

      rst_d = 1'b1; ce = 1'b0; flush = 1'b0; stall = 6'b0; flush_tgt = 32'h0;
      rand_mode = 1'b0; gnt_wait = 0; rv_wait = 0; force_en = 1'b0; force_val = 32'h0;
      mem_busy = 1'b0; mem_dead = 1'b0; mem_pc = 32'h0; mem_data = 32'h0;
      rv_cnt = 0; req_wait = 0; model_pc = 32'h0;
      rst = 1'b1; pc_i = 32'h0; ce_i = 1'b0; stall_w = 6'b0; flush_w = 1'b0;
      imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0; imem_rdata_i = 32'h0;
      repeat (2) @(posedge clk);
      #1;

      // reset state
      ce = 1'b1;
      cycle();
      chk("rst_req", 64'(s_req), 64'd0);
      chk("rst_addr", 64'(s_addr), 64'd0);
      chk("rst_valid", 64'(s_valid), 64'd0);
      chk("rst_pc", 64'(s_pc), 64'd0);
      chk("rst_inst", 64'(s_inst), 64'd0);
      chk("rst_stallreq", 64'(s_stallreq), 64'd0);

      // zero-wait streaming from 0x0
      drain();
      model_pc = 32'h0; ce = 1'b1;
      first_valid = -1; npop = 0;
      for (int i = 0; i < 12; i++) begin
         cycle();
         if (s_valid && first_valid < 0) first_valid = i;
         if (s_valid && npop < 3) begin
            got_pc[npop] = s_pc;
            npop++;
         end
      end
      chk("t1_latency", 64'(first_valid), 64'd3);
      chk("t1_npop", 64'(npop), 64'd3);
      chk("t1_pc0", 64'(got_pc[0]), 64'h0);
      chk("t1_pc1", 64'(got_pc[1]), 64'h4);
      chk("t1_pc2", 64'(got_pc[2]), 64'h8);

      // grant delayed by three cycles at 0x10
      drain();
      model_pc = 32'h10; ce = 1'b1; gnt_wait = 3; stall = 6'b000010;
      held = 0; granted = 1'b0;
      for (int i = 0; i < 20 && !granted; i++) begin
         cycle();
         if (s_req && !s_gnt && s_addr == 32'h10 && s_stallreq) held++;
         if (s_req && s_gnt) begin
            granted = 1'b1;
            ce = 1'b0;
         end
      end
      chk("t2_granted", 64'(granted), 64'd1);
      chk("t2_held", 64'(held), 64'd3);
      repeat (4) cycle();
      chk("t2_valid", 64'(s_valid), 64'd1);
      chk("t2_pc", 64'(s_pc), 64'h10);
      stall = 6'b0;
      cycle();
      cycle();
      chk("t2_single", 64'(s_valid), 64'd0);

      // decode stalled: buffer fills to DEPTH, then release one pop
      drain();
      model_pc = 32'h20; ce = 1'b1; stall = 6'b000010;
      repeat (10) cycle();
      chk("t3_noreq", 64'(s_req), 64'd0);
      chk("t3_stallreq", 64'(s_stallreq), 64'd1);
      chk("t3_head", 64'(s_pc), 64'h20);
      stall = 6'b0;
      cycle();
      chk("t3_pop_pc", 64'(s_pc), 64'h20);
      stall = 6'b000010;
      found = 1'b0;
      for (int i = 0; i < 4 && !found; i++) begin
         cycle();
         if (s_req) begin
            found = 1'b1;
            chk("t3_next_addr", 64'(s_addr), 64'h28);
         end
      end
      chk("t3_req_seen", 64'(found), 64'd1);

      // flush while waiting for the 0x30 response with one entry buffered
      drain();
      model_pc = 32'h2C; ce = 1'b1; stall = 6'b000010; rv_wait = 2;
      force_val = 32'hDEADBEEF; granted = 1'b0;
      for (int i = 0; i < 30 && !granted; i++) begin
         force_en = (model_pc == 32'h30);
         cycle();
         if (mem_busy && mem_pc == 32'h30) granted = 1'b1;
      end
      force_en = 1'b0;
      chk("t4_setup", 64'(granted), 64'd1);
      chk("t4_buffered", 64'(s_valid), 64'd1);
      flush = 1'b1; flush_tgt = 32'h100;
      cycle();
      flush = 1'b0; stall = 6'b0;
      cycle();
      chk("t4_flushed", 64'(s_valid), 64'd0);
      seen = 1'b0; found = 1'b0;
      for (int i = 0; i < 10; i++) begin
         cycle();
         if (s_valid && s_inst == 32'hDEADBEEF) seen = 1'b1;
         if (s_req && !found) begin
            found = 1'b1;
            chk("t4_target_addr", 64'(s_addr), 64'h100);
         end
      end
      chk("t4_no_stale", 64'(seen), 64'd0);
      chk("t4_req_seen", 64'(found), 64'd1);

      // flush in the same cycle as rvalid
      drain();
      model_pc = 32'h200; ce = 1'b1; rv_wait = 2;
      for (int i = 0; i < 10 && !mem_busy; i++) cycle();
      flag = 1'b0;
      for (int i = 0; i < 10 && !flag; i++) begin
         flush = mem_busy && (rv_cnt == 0);
         flush_tgt = 32'h300;
         cycle();
         if (flush) begin
            flag = 1'b1;
            chk("t5_stallreq", 64'(s_stallreq), 64'd0);
         end
      end
      chk("t5_flush_hit", 64'(flag), 64'd1);
      flush = 1'b0;
      cycle();
      chk("t5_empty", 64'(s_valid), 64'd0);
      chk("t5_idle", 64'(s_req), 64'd0);
      cycle();
      chk("t5_req", 64'(s_req), 64'd1);
      chk("t5_addr", 64'(s_addr), 64'h300);

      // reset while in RESP; response lands one cycle after reset releases
      drain();
      model_pc = 32'h500; ce = 1'b1; rv_wait = 3;
      for (int i = 0; i < 10 && !mem_busy; i++) cycle();
      rst_d = 1'b1; model_pc = 32'h400;
      cycle();
      cycle();
      chk("t6_req", 64'(s_req), 64'd0);
      chk("t6_addr", 64'(s_addr), 64'd0);
      chk("t6_valid", 64'(s_valid), 64'd0);
      chk("t6_pc", 64'(s_pc), 64'd0);
      chk("t6_inst", 64'(s_inst), 64'd0);
      chk("t6_stallreq", 64'(s_stallreq), 64'd0);
      rst_d = 1'b0;
      cycle();
      chk("t6_idle", 64'(s_req), 64'd0);
      cycle();
      cycle();
      chk("t6_ignored", 64'(s_valid), 64'd0);
      found = 1'b0; cnt = 0;
      for (int i = 0; i < 8 && !found; i++) begin
         cycle();
         if (s_valid) begin
            found = 1'b1;
            chk("t6_resume_pc", 64'(s_pc), 64'h400);
         end
      end
      chk("t6_resumed", 64'(found), 64'd1);

      // randomized traffic against the model
      rand_mode = 1'b1;
      n_push = 0;
      for (int i = 0; i < 3000; i++) begin
         ce    = ($urandom_range(0, 9) != 0);
         stall = 6'($urandom_range(0, 63)) & 6'b111101;
         if ($urandom_range(0, 9) < 3) stall[1] = 1'b1;
         flush = ($urandom_range(0, 19) == 0);
         flush_tgt = 32'($urandom_range(0, 65535)) << 2;
         rst_d = ($urandom_range(0, 399) == 0);
         cycle();
         cnt++;
      end
      rst_d = 1'b0; flush = 1'b0;
      chk("rand_progress", 64'(n_push > 300), 64'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
